// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared state encodings and widths for DAC-rate blocks
package dac_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PREFILL = 2'b01,
        ST_RUN     = 2'b10
    } dac_state_t;

    localparam int UCNT_W = 16;

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - reloadable down-counter producing one tick every div+1 cycles
module sample_tick_gen #(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    // div is only sampled on a load or a reload, so changes land at the next period boundary
    always_ff @(posedge clk) begin
        if (rst || load || cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = !load && (cnt == '0);

endmodule

// File: rtl/dac_sample_sched.sv
// rtl/dac_sample_sched.sv - DAC playout scheduler: FIFO gating, level tracking, prefill and underrun recovery
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 4,
    parameter int DIVW      = 16,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIVW-1:0]   div,
    input  logic [AWIDTH:0]   prefill,
    input  logic              up_valid,
    input  logic [DWIDTH-1:0] up_data,
    output logic              up_ready,
    output logic [DWIDTH-1:0] fifo_wdata,
    output logic              fifo_write_en,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_read_en,
    output logic [DWIDTH-1:0] dac_data,
    output logic              dac_strobe,
    output logic [AWIDTH:0]   level,
    output logic [1:0]        state,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int              DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] ONE_L   = (AWIDTH+1)'(1);

    dac_state_t      st_q, st_d;
    logic [AWIDTH:0] level_q;
    logic [AWIDTH:0] eff_prefill;
    logic            tick, tick_ok, load, push, pop;

    assign load = !(st_q == ST_PREFILL || st_q == ST_RUN);

    sample_tick_gen #(.DIVW(DIVW)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .div  (div),
        .tick (tick)
    );

    // a tick arriving while enable is low is dropped, not deferred
    assign tick_ok       = tick && enable;
    assign up_ready      = !fifo_full;
    assign fifo_wdata    = up_data;
    assign fifo_write_en = up_valid && !fifo_full;
    assign fifo_read_en  = (st_q == ST_RUN) && tick_ok && !fifo_empty;
    assign push          = fifo_write_en;
    assign pop           = fifo_read_en && !fifo_empty;

    always_comb begin
        eff_prefill = prefill;
        if (prefill == '0) begin
            eff_prefill = ONE_L;
        end else if (prefill > DEPTH_L) begin
            eff_prefill = DEPTH_L;
        end
    end

    always_comb begin
        st_d = st_q;
        if (!enable) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE:    st_d = ST_PREFILL;
                ST_PREFILL: if (level_q >= eff_prefill) st_d = ST_RUN;
                ST_RUN:     if (tick && fifo_empty) st_d = ST_PREFILL;
                default:    st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            level_q      <= '0;
            dac_data     <= '0;
            dac_strobe   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            st_q       <= st_d;
            dac_strobe <= 1'b0;
            underrun   <= 1'b0;
            if (push && !pop && level_q != DEPTH_L) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push && level_q != '0) begin
                level_q <= level_q - 1'b1;
            end
            // every surviving tick strobes, so cadence holds through prefill and underrun
            if (tick_ok) begin
                dac_strobe <= 1'b1;
                if (fifo_read_en) begin
                    dac_data <= fifo_rdata;
                end else if (!HOLD_LAST) begin
                    dac_data <= '0;
                end
                if (st_q == ST_RUN && fifo_empty) begin
                    underrun <= 1'b1;
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + UCNT_W'(1);
                    end
                end
            end
        end
    end

    assign level = level_q;
    assign state = st_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb/tb_dac_sample_sched.sv - randomized self-checking bench for dac_sample_sched
module tb_dac_sample_sched;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DIVW  = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, enable, up_valid;
    logic [DIVW-1:0] div;
    logic [AW:0]     prefill;
    logic [DW-1:0]   up_data;
    logic            fifo_full, fifo_empty;
    logic [DW-1:0]   fifo_rdata;

    logic            up_ready, fifo_write_en, fifo_read_en, dac_strobe, underrun;
    logic [DW-1:0]   fifo_wdata, dac_data;
    logic [AW:0]     level;
    logic [1:0]      state;
    logic [15:0]     underrun_cnt;

    logic            z_up_ready, z_fifo_write_en, z_fifo_read_en, z_dac_strobe, z_underrun;
    logic [DW-1:0]   z_fifo_wdata, z_dac_data;
    logic [AW:0]     z_level;
    logic [1:0]      z_state;
    logic [15:0]     z_underrun_cnt;

    dac_sample_sched #(.DWIDTH(DW), .AWIDTH(AW), .DIVW(DIVW), .HOLD_LAST(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .div(div), .prefill(prefill),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
        .fifo_wdata(fifo_wdata), .fifo_write_en(fifo_write_en),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_read_en(fifo_read_en), .dac_data(dac_data), .dac_strobe(dac_strobe),
        .level(level), .state(state), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    dac_sample_sched #(.DWIDTH(DW), .AWIDTH(AW), .DIVW(DIVW), .HOLD_LAST(1'b0)) dut_zero (
        .clk(clk), .rst(rst), .enable(enable), .div(div), .prefill(prefill),
        .up_valid(up_valid), .up_data(up_data), .up_ready(z_up_ready),
        .fifo_wdata(z_fifo_wdata), .fifo_write_en(z_fifo_write_en),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_read_en(z_fifo_read_en), .dac_data(z_dac_data), .dac_strobe(z_dac_strobe),
        .level(z_level), .state(z_state), .underrun(z_underrun), .underrun_cnt(z_underrun_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // reference model: FIFO contents, occupancy, playout mode and cycles left in the period
    logic [DW-1:0] q[$];
    int            m_mode, m_level, m_left, m_ucnt;
    logic [DW-1:0] m_data1, m_data0;
    bit            m_strobe, m_under;
    int            rd_cnt;

    task automatic drive_fifo();
        fifo_full  = (q.size() >= DEPTH);
        fifo_empty = (q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : q[0];
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_level = 0; m_left = int'(div); m_ucnt = 0;
        m_data1 = '0; m_data0 = '0; m_strobe = 0; m_under = 0;
    endtask

    task automatic step();
        int eff, old_mode;
        bit tick, full, empty, push, pop;
        logic [DW-1:0] head;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        head  = empty ? '0 : q[0];
        eff   = (prefill == 0) ? 1 : ((int'(prefill) > DEPTH) ? DEPTH : int'(prefill));
        tick  = (m_mode != 0) && (m_left == 0);
        push  = up_valid && !full;
        pop   = (m_mode == 2) && tick && enable && !empty;
        #1;
        if (!rst) begin
            chk("up_ready", up_ready, !full);
            chk("fifo_write_en", fifo_write_en, push);
            chk("fifo_read_en", fifo_read_en, pop);
            chk("fifo_wdata", fifo_wdata, up_data);
            chk("z_fifo_read_en", z_fifo_read_en, pop);
            if (fifo_read_en) rd_cnt++;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            old_mode = m_mode;
            m_strobe = 0;
            m_under  = 0;
            if (!enable) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (tick) begin m_strobe = 1; m_data0 = '0; end
                if (m_level >= eff) m_mode = 2;
            end else if (tick) begin
                m_strobe = 1;
                if (!empty) begin
                    m_data1 = head; m_data0 = head;
                end else begin
                    m_under = 1; m_data0 = '0; m_mode = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (old_mode == 0 || m_left == 0) m_left = int'(div);
            else m_left--;
            m_level += (push ? 1 : 0) - (pop ? 1 : 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(up_data);
        end
        @(negedge clk);
        drive_fifo();
        chk("state", state, m_mode);
        chk("level", level, m_level);
        chk("dac_strobe", dac_strobe, m_strobe);
        chk("dac_data", dac_data, m_data1);
        chk("z_dac_data", z_dac_data, m_data0);
        chk("underrun", underrun, m_under);
        chk("underrun_cnt", underrun_cnt, m_ucnt);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; up_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int            s_idx[$];
    logic [DW-1:0] s_d1[$], s_d0[$];
    logic [DW-1:0] exp1[5], exp0[5];
    bit            seen_run;
    int            pv;

    initial begin
        rst = 1'b1; enable = 1'b0; up_valid = 1'b0; up_data = '0;
        div = 16'd3; prefill = 5'd4;
        fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
        rd_cnt = 0;
        model_reset();
        @(negedge clk);

        do_reset();
        chk("rst_state", state, 2'b00);
        chk("rst_level", level, 0);
        chk("rst_strobe", dac_strobe, 1'b0);
        chk("rst_data", dac_data, 0);
        chk("rst_ucnt", underrun_cnt, 0);

        // idle pushes then basic playout and underrun
        exp1[0] = 32'h11; exp1[1] = 32'h22; exp1[2] = 32'h33; exp1[3] = 32'h44; exp1[4] = 32'h44;
        exp0[0] = 32'h11; exp0[1] = 32'h22; exp0[2] = 32'h33; exp0[3] = 32'h44; exp0[4] = 32'h0;
        up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_data = exp1[i];
            step();
        end
        chk("idle_level", level, 4);
        chk("idle_state", state, 2'b00);
        up_valid = 1'b0; enable = 1'b1; rd_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dac_strobe) begin
                s_idx.push_back(i); s_d1.push_back(dac_data); s_d0.push_back(z_dac_data);
            end
        end
        chk("strobe_count_ge6", s_idx.size() >= 6, 1'b1);
        for (int k = 0; k < 5 && k < s_idx.size(); k++) begin
            chk("play_data", s_d1[k], exp1[k]);
            chk("play_data_zero", s_d0[k], exp0[k]);
        end
        for (int k = 0; k + 1 < s_idx.size(); k++) chk("strobe_period", s_idx[k+1] - s_idx[k], 4);
        chk("play_reads", rd_cnt, 4);
        chk("under_cnt", underrun_cnt, 1);
        chk("under_state", state, 2'b01);

        // prefill 0 behaves as 1
        div = 16'd0; prefill = 5'd0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("pf0_wait", state, 2'b01);
        up_valid = 1'b1; up_data = 32'hA5A5_0001;
        step();
        up_valid = 1'b0;
        step();
        chk("pf0_run", state, 2'b10);

        // prefill 31 clamps to a full FIFO
        prefill = 5'd31;
        do_reset();
        enable = 1'b1; up_valid = 1'b1; seen_run = 0;
        for (int i = 0; i < 30 && !seen_run; i++) begin
            up_data = $urandom;
            step();
            if (state == 2'b10) begin
                seen_run = 1;
                chk("pf31_level", level, 16);
                #1;
                chk("full_up_ready", up_ready, 1'b0);
                chk("full_write_en", fifo_write_en, 1'b0);
            end
        end
        chk("pf31_reached_run", seen_run, 1'b1);

        // enable drop mid-run
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        step();
        chk("drop_state", state, 2'b00);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ucnt", underrun_cnt, 0);
        chk("rst2_data", dac_data, 0);
        chk("rst2_level", level, 0);

        // randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            div     = 16'($urandom_range(0, 5));
            prefill = 5'($urandom_range(0, 31));
            pv      = $urandom_range(1, 9);
            for (int i = 0; i < 250; i++) begin
                rst      = ($urandom_range(0, 299) == 0);
                enable   = ($urandom_range(0, 29) != 0);
                up_valid = ($urandom_range(0, 9) < pv);
                up_data  = $urandom;
                if ($urandom_range(0, 99) == 0) div = 16'($urandom_range(0, 5));
                step();
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Playout controller for the DAC sample FIFO. It gates upstream writes into `syncfifo` and tracks FIFO occupancy. It holds off playout until a programmable prefill level is reached, then pops one sample per programmable sample period and presents it to the DAC as a registered data and strobe pair. Underruns are detected, counted and recovered by re-entering prefill, so the DAC strobe cadence is never interrupted.

## Interface
- `DWIDTH`, 32, sample width; must match the FIFO.
- `AWIDTH`, 4, FIFO address width; FIFO depth is `DEPTH = 2**AWIDTH`.
- `DIVW`, 16, width of the sample-period divider.
- `HOLD_LAST`, 1, underrun output policy: 1 holds the last sample, 0 outputs zero.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  playout enable.
- `div`  in  DIVW  sample period minus 1, in clk cycles.
- `prefill`  in  AWIDTH+1  level required to start playout; 0 is treated as 1, values above DEPTH clamp to DEPTH.
- `up_valid`  in  1  upstream sample valid.
- `up_data`  in  DWIDTH  upstream sample.
- `up_ready`  out  1  equals `!fifo_full`.
- `fifo_wdata`  out  DWIDTH  equals `up_data`.
- `fifo_write_en`  out  1  equals `up_valid && !fifo_full`.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  DWIDTH  FIFO head data, combinational.
- `fifo_read_en`  out  1  pop request.
- `dac_data`  out  DWIDTH  registered sample to the DAC.
- `dac_strobe`  out  1  one-cycle pulse, once per sample period.
- `level`  out  AWIDTH+1  tracked FIFO occupancy.
- `state`  out  2  current state.
- `underrun`  out  1  one-cycle pulse on underrun.
- `underrun_cnt`  out  16  saturating underrun count.

## Operation
- Reset: state IDLE. `level`, `dac_data`, `dac_strobe`, `underrun` and `underrun_cnt` are all 0. The divider counter loads `div`.
- Push: `push = fifo_write_en`. Pop: `pop = fifo_read_en && !fifo_empty`.
- `level` update is +1 on push only, −1 on pop only, and unchanged when both or neither occur. `level` never exceeds DEPTH and never goes below 0.
- Writes and level tracking continue in every state, including IDLE.
- Divider behaviour:
  - In IDLE, the counter continuously loads `div`.
  - Otherwise it decrements, and `tick = (cnt == 0)`, at which point it reloads `div`.
  - A change to `div` takes effect at the next reload.
- State IDLE (00): no ticks. Moves to PREFILL when `enable` is high.
- State PREFILL (01):
  - On each tick: `dac_strobe` pulses with `dac_data` = last sample if HOLD_LAST, else 0. No pop.
  - Moves to RUN when `level >= eff_prefill`.
- State RUN (10): on a tick, behaviour depends on `fifo_empty`.
  - `fifo_empty` = 0: assert `fifo_read_en` combinationally in the tick cycle; `dac_data <= fifo_rdata`; `dac_strobe <= 1`.
  - `fifo_empty` = 1: `underrun` pulses, `underrun_cnt` increments (saturating at 0xFFFF), `dac_strobe` pulses with the held or zero value, and the state moves to PREFILL.
- `enable` low in any state: move to IDLE on the next edge. In-flight ticks are dropped, the FIFO is not flushed, and `dac_data` holds its value.
- `fifo_read_en` is asserted only in RUN, on a tick, with `!fifo_empty`.
- Encoding 11 is unused; if reached, the next state is IDLE.

## Timing
- `up_ready`, `fifo_write_en` and `fifo_read_en` are combinational. All other outputs are registered.
- Tick in cycle t: the pop is accepted at edge t+1, and `dac_data`/`dac_strobe` are valid in cycle t+1.
- Strobe period is exactly `div+1` cycles in PREFILL and RUN, including across underrun transitions.
- The first tick occurs `div+1` cycles after IDLE→PREFILL.
- The PREFILL→RUN check uses the registered `level`, so RUN is entered the cycle after the threshold is met.
- `rst` mid-operation returns everything to reset values on the next edge, with reset taking priority over all events.

## Structure
- Shared package `dac_sched_pkg` holds:
  - State encodings: `ST_IDLE`, `ST_PREFILL`, `ST_RUN`.
  - `UCNT_W = 16`.
- Sub-module `sample_tick_gen`: a divider with `load`/`div` inputs and a `tick` output, reusable by other DAC-rate blocks.
- The FSM, level tracker and output registers live in the top module.

## Test plan
1. Reset and idle with `up_valid = 1` → all registered outputs 0, state 00, and `fifo_write_en` follows `!fifo_full`, so `level` climbs while state stays IDLE.
2. Basic playout with `div = 3`, `prefill = 4`:
   - Push 0x11, 0x22, 0x33, 0x44, then raise `enable` → RUN entered after the threshold.
   - `dac_strobe` pulses every 4 cycles with 0x11, 0x22, 0x33, 0x44 in order.
   - `fifo_read_en` is high for exactly one cycle per tick.
3. Underrun, starting from case 2 with no further pushes:
   - The fifth tick → `underrun` pulse, `underrun_cnt = 1`, state PREFILL, strobe still on cadence.
   - With HOLD_LAST = 1, `dac_data = 0x44`; with HOLD_LAST = 0, `dac_data = 0`.
4. Simultaneous push and pop in a RUN tick cycle → `level` unchanged. With `fifo_full = 1` → `up_ready = 0`, `fifo_write_en = 0`, `level` stays at 16.
5. `prefill = 0` → RUN after the first push. `prefill = 31` → clamped to 16, so RUN only once the FIFO is full.
6. `enable` dropped mid-RUN → IDLE next cycle, no further strobes or pops, `dac_data` held. Then `rst` → all outputs 0; `underrun_cnt` driven to 0xFFFF saturates there.
